// File: rtl/truth_table_prober.sv
// rtl/truth_table_prober.sv - sweeps 8 stimuli into a 3-input gate and assembles its truth-table code
module truth_table_prober #(
  parameter int SETTLE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expected,
  output logic [2:0] stim,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic [7:0] unstable_mask,
  output logic       match
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES);
  localparam logic [7:0] HOLD_INIT   = 8'(HOLD_CYCLES);

  logic [1:0] state_q, state_d;
  logic [2:0] stim_q, stim_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] exp_q, exp_d;
  logic [7:0] work_tbl_q, work_tbl_d;
  logic [7:0] work_unst_q, work_unst_d;
  logic       done_q, done_d;
  logic [7:0] table_q, table_d;
  logic [7:0] mask_q, mask_d;
  logic       match_q, match_d;

  // Response to stimulus i lands in bit (7-i), so stimulus 000 is the MSB.
  logic [2:0] bit_idx;
  assign bit_idx = ~stim_q;

  assign stim          = stim_q;
  assign busy          = (state_q == ST_SETTLE) || (state_q == ST_HOLD);
  assign done          = done_q;
  assign table_out     = table_q;
  assign unstable_mask = mask_q;
  assign match         = match_q;

  // Sweep sequencing: settle countdown, hold-window sampling, result publication.
  always_comb begin
    state_d     = state_q;
    stim_d      = stim_q;
    cnt_d       = cnt_q;
    exp_d       = exp_q;
    work_tbl_d  = work_tbl_q;
    work_unst_d = work_unst_q;
    done_d      = 1'b0;
    table_d     = table_q;
    mask_d      = mask_q;
    match_d     = match_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          exp_d       = expected;
          state_d     = ST_SETTLE;
          stim_d      = 3'd0;
          cnt_d       = SETTLE_INIT;
          work_tbl_d  = 8'h00;
          work_unst_d = 8'h00;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          stim_d  = 3'd0;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'd1) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_INIT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          state_d = ST_IDLE;
          stim_d  = 3'd0;
          cnt_d   = 8'd0;
        end else begin
          // First hold cycle captures; later cycles only flag disagreement.
          if (cnt_q == HOLD_INIT) begin
            work_tbl_d[bit_idx] = dut_out;
          end else if (dut_out != work_tbl_q[bit_idx]) begin
            work_unst_d[bit_idx] = 1'b1;
          end
          if (cnt_q == 8'd1) begin
            if (stim_q == 3'd7) begin
              state_d = ST_DONE;
              cnt_d   = 8'd0;
              done_d  = 1'b1;
              table_d = work_tbl_d;
              mask_d  = work_unst_d;
              match_d = (work_tbl_d == exp_q) && (work_unst_d == 8'h00);
            end else begin
              state_d = ST_SETTLE;
              stim_d  = stim_q + 3'd1;
              cnt_d   = SETTLE_INIT;
            end
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        stim_d  = 3'd0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State and result registers; reset discards any partial sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      stim_q      <= 3'd0;
      cnt_q       <= 8'd0;
      exp_q       <= 8'h00;
      work_tbl_q  <= 8'h00;
      work_unst_q <= 8'h00;
      done_q      <= 1'b0;
      table_q     <= 8'h00;
      mask_q      <= 8'h00;
      match_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      stim_q      <= stim_d;
      cnt_q       <= cnt_d;
      exp_q       <= exp_d;
      work_tbl_q  <= work_tbl_d;
      work_unst_q <= work_unst_d;
      done_q      <= done_d;
      table_q     <= table_d;
      mask_q      <= mask_d;
      match_q     <= match_d;
    end
  end

endmodule

// File: tb/tb_truth_table_prober.sv
// tb/tb_truth_table_prober.sv - self-checking bench for truth_table_prober
module tb_truth_table_prober;

  localparam int S    = 4;
  localparam int H0   = 2;
  localparam int H1   = 3;
  localparam int VEC0 = S + H0;
  localparam int VEC1 = S + H1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] expected = 8'h00;

  // resp[i] is the gate response to stimulus value i
  logic [7:0] resp0 = 8'h00;
  logic [7:0] resp1 = 8'h00;
  logic       glitch_en = 1'b0;

  logic [2:0] stim0, stim1;
  logic       dut_out0, dut_out1;
  logic       busy0, busy1, done0, done1, match0, match1;
  logic [7:0] table0, table1, mask0, mask1;

  logic [2:0] prev1 = 3'd0;
  int         age1 = 0;
  logic       g1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign dut_out0 = resp0[stim0];
  assign g1 = glitch_en && (stim1 == 3'd5) && (age1 >= S + 1) && (((age1 - S - 1) % 2) == 1);
  assign dut_out1 = resp1[stim1] ^ g1;

  always @(negedge clk) begin
    if (stim1 != prev1) begin
      prev1 <= stim1;
      age1  <= 1;
    end else begin
      age1 <= age1 + 1;
    end
  end

  truth_table_prober #(.SETTLE_CYCLES(S), .HOLD_CYCLES(H0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
    .stim(stim0), .dut_out(dut_out0), .busy(busy0), .done(done0),
    .table_out(table0), .unstable_mask(mask0), .match(match0)
  );

  truth_table_prober #(.SETTLE_CYCLES(S), .HOLD_CYCLES(H1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
    .stim(stim1), .dut_out(dut_out1), .busy(busy1), .done(done1),
    .table_out(table1), .unstable_mask(mask1), .match(match1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_code(input logic [7:0] resp);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < 8; i++) c[7 - i] = resp[i];
    return c;
  endfunction

  // Pulse start, follow the sweep on instance 0; optionally pulse start again at step inj_m.
  task automatic sweep0(input logic [7:0] exp_code, input int inj_m,
                        output int m_done, output bit stim_ok, output bit busy_ok);
    int m;
    @(negedge clk);
    expected = exp_code;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    expected = 8'($urandom);
    m = 0; stim_ok = 1'b1; busy_ok = 1'b1; m_done = -1;
    while (m < 8 * VEC0 + 20) begin
      if (done0 === 1'b1) begin
        m_done = m;
        break;
      end
      if (stim0 !== 3'(m / VEC0)) stim_ok = 1'b0;
      if (busy0 !== 1'b1) busy_ok = 1'b0;
      if (m == inj_m) begin
        start    = 1'b1;
        expected = 8'h00;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      m++;
    end
    start = 1'b0;
  endtask

  task automatic post0(input string tag, input logic [7:0] t, input logic [7:0] msk,
                       input logic mt, input int m_done, input bit sok, input bit bok);
    chk({tag, "_done_latency"}, 32'(m_done), 32'(8 * VEC0));
    chk({tag, "_stim_trajectory"}, 32'(sok), 32'd1);
    chk({tag, "_busy_during"}, 32'(bok), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy0), 32'd0);
    chk({tag, "_stim_at_done"}, 32'(stim0), 32'd7);
    chk({tag, "_table"}, 32'(table0), 32'(t));
    chk({tag, "_mask"}, 32'(mask0), 32'(msk));
    chk({tag, "_match"}, 32'(match0), 32'(mt));
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 32'(done0), 32'd0);
    chk({tag, "_table_held"}, 32'(table0), 32'(t));
  endtask

  initial begin
    int  md;
    bit  sok, bok;
    int  m;
    bit  saw_done;
    logic [7:0] r, code, ex;

    // Reset state
    #1 rst_n = 1'b0;
    #20;
    chk("rst_stim", 32'(stim0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_table", 32'(table0), 32'd0);
    chk("rst_mask", 32'(mask0), 32'd0);
    chk("rst_match", 32'(match0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 0x91 gate: outputs 1 at stimuli 000, 011, 111
    resp0 = 8'h00; resp0[0] = 1'b1; resp0[3] = 1'b1; resp0[7] = 1'b1;
    sweep0(8'h91, -1, md, sok, bok);
    post0("r91", 8'h91, 8'h00, 1'b1, md, sok, bok);

    // Abort at step 20 of a sweep following the 0x91 result
    @(negedge clk);
    expected = 8'h91;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 19; i++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_stim", 32'(stim0), 32'd0);
    chk("abort_done", 32'(done0), 32'd0);
    chk("abort_table_kept", 32'(table0), 32'h91);
    chk("abort_match_kept", 32'(match0), 32'd1);
    saw_done = 1'b0;
    for (int i = 0; i < 8 * VEC1 + 10; i++) begin
      @(negedge clk);
      if (done0 === 1'b1) saw_done = 1'b1;
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);

    // Constant-1 gate against expected 0x91
    resp0 = 8'hFF;
    sweep0(8'h91, -1, md, sok, bok);
    post0("const1", 8'hFF, 8'h00, 1'b0, md, sok, bok);

    // start with expected=0 while busy must be ignored
    r    = 8'($urandom);
    resp0 = r;
    code = model_code(r);
    sweep0(code, 10, md, sok, bok);
    post0("busy_start", code, 8'h00, 1'b1, md, sok, bok);

    // Random gates, expected either the true code or a random value
    for (int n = 0; n < 4; n++) begin
      r     = 8'($urandom);
      resp0 = r;
      code  = model_code(r);
      ex    = ($urandom_range(0, 1) == 1) ? code : 8'($urandom);
      sweep0(ex, -1, md, sok, bok);
      post0($sformatf("rand%0d", n), code, 8'h00, code == ex, md, sok, bok);
    end

    // Instance 1 (H=3): glitch inside the hold window of stimulus 5 only
    m = 0;
    while (busy1 === 1'b1 && m < 200) begin
      @(negedge clk);
      m++;
    end
    chk("u1_idle_before_glitch", 32'(busy1), 32'd0);
    resp1 = 8'h00; resp1[0] = 1'b1; resp1[3] = 1'b1; resp1[7] = 1'b1;
    glitch_en = 1'b1;
    @(negedge clk);
    expected = 8'h91;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m = 0; md = -1;
    while (m < 8 * VEC1 + 20) begin
      if (done1 === 1'b1) begin
        md = m;
        break;
      end
      @(negedge clk);
      m++;
    end
    glitch_en = 1'b0;
    chk("glitch_done_latency", 32'(md), 32'(8 * VEC1));
    chk("glitch_table", 32'(table1), 32'h91);
    chk("glitch_mask", 32'(mask1), 32'h04);
    chk("glitch_match", 32'(match1), 32'd0);

    // Level-held start re-triggers after each done
    resp0 = 8'h00; resp0[0] = 1'b1; resp0[3] = 1'b1; resp0[7] = 1'b1;
    @(negedge clk);
    expected = 8'h91;
    start    = 1'b1;
    m = 0;
    while (done0 !== 1'b1 && m < 8 * VEC0 + 20) begin
      @(negedge clk);
      m++;
    end
    chk("held_first_done", 32'(done0), 32'd1);
    @(negedge clk);
    chk("held_rebusy", 32'(busy0), 32'd1);
    chk("held_rebusy_done_low", 32'(done0), 32'd0);
    m = 0; md = -1;
    while (m < 8 * VEC0 + 20) begin
      if (done0 === 1'b1) begin
        md = m;
        break;
      end
      @(negedge clk);
      m++;
    end
    start = 1'b0;
    chk("held_second_latency", 32'(md), 32'(8 * VEC0));
    chk("held_table", 32'(table0), 32'h91);
    chk("held_match", 32'(match0), 32'd1);

    // Reset in the middle of a sweep
    @(negedge clk);
    @(negedge clk);
    expected = 8'h91;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 19; i++) @(negedge clk);
    chk("pre_rst_busy", 32'(busy0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stim", 32'(stim0), 32'd0);
    chk("mid_rst_busy", 32'(busy0), 32'd0);
    chk("mid_rst_table", 32'(table0), 32'd0);
    chk("mid_rst_mask", 32'(mask0), 32'd0);
    chk("mid_rst_match", 32'(match0), 32'd0);
    chk("mid_rst_done", 32'(done0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_idle_busy", 32'(busy0), 32'd0);
    chk("post_rst_idle_stim", 32'(stim0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
